// File: rtl/cache_mem_ctrl.sv
// Block writeback/fill sequencer between cache and single-word RAM; CACHE_MEM_CRITICAL_WORD_FIRST_EN rotates fill order.
// Latency: BLOCK_SIZE acked words per phase, then one-cycle ram_valid and HOLD_CYCLES of ignored requests; mem_ack low stalls.
module cache_mem_ctrl #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int HOLD_CYCLES      = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [RAM_ADDRESS_BITS-1:0]               prop_address,
    input  logic [RAM_ADDRESS_BITS-1:0]               prop_wb_address,
    input  logic                                      prop_read_en,
    input  logic                                      prop_write_en,
    input  logic [2**BLOCK_BITS-1:0][DATA_BITS-1:0]   prop_write_data,
    output logic                                      ram_valid,
    output logic [2**BLOCK_BITS-1:0][DATA_BITS-1:0]   ram_data,
    output logic                                      busy,
    output logic [RAM_ADDRESS_BITS-1:0]               mem_address,
    output logic                                      mem_read_en,
    output logic                                      mem_write_en,
    output logic [DATA_BITS-1:0]                      mem_write_data,
    input  logic                                      mem_ack,
    input  logic [DATA_BITS-1:0]                      mem_read_data
);
    localparam int BLOCK_SIZE = 2**BLOCK_BITS;
    localparam logic [RAM_ADDRESS_BITS-1:0] OFF_MASK = RAM_ADDRESS_BITS'(BLOCK_SIZE-1);

    typedef enum logic [2:0] {IDLE, WB, FILL, DONE, HOLD} state_t;
    typedef logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] block_t;

    state_t                      state_q, state_d;
    logic [BLOCK_BITS-1:0]       word_cnt_q, word_cnt_d, word_cnt_nxt;
    logic [BLOCK_BITS:0]         xfer_cnt_q, xfer_cnt_d, xfer_cnt_nxt;
    logic [3:0]                  hold_cnt_q, hold_cnt_d;
    logic [RAM_ADDRESS_BITS-1:0] wb_addr_q, wb_addr_d;
    logic [RAM_ADDRESS_BITS-1:0] fill_addr_q, fill_addr_d;
    logic                        fill_pend_q, fill_pend_d;
    block_t                      wb_data_q, wb_data_d;
    logic                        ram_valid_q, ram_valid_d;
    block_t                      ram_data_q, ram_data_d;
    logic                        busy_q, busy_d;
    logic [RAM_ADDRESS_BITS-1:0] mem_address_q, mem_address_d;
    logic                        mem_read_en_q, mem_read_en_d;
    logic                        mem_write_en_q, mem_write_en_d;
    logic [DATA_BITS-1:0]        mem_write_data_q, mem_write_data_d;
    logic [BLOCK_BITS-1:0]       start_in, start_q;
    logic                        phase_last;

    function automatic logic [RAM_ADDRESS_BITS-1:0] word_addr(
        input logic [RAM_ADDRESS_BITS-1:0] a,
        input logic [BLOCK_BITS-1:0]       off
    );
        return (a & ~OFF_MASK) | RAM_ADDRESS_BITS'(off);
    endfunction

`ifdef CACHE_MEM_CRITICAL_WORD_FIRST_EN
    assign start_in = prop_address[BLOCK_BITS-1:0];
    assign start_q  = fill_addr_q[BLOCK_BITS-1:0];
`else
    assign start_in = '0;
    assign start_q  = '0;
`endif

    assign word_cnt_nxt = word_cnt_q + 1'b1;
    assign xfer_cnt_nxt = xfer_cnt_q + 1'b1;
    assign phase_last   = (xfer_cnt_nxt == (BLOCK_BITS+1)'(BLOCK_SIZE));

    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        xfer_cnt_d       = xfer_cnt_q;
        hold_cnt_d       = hold_cnt_q;
        wb_addr_d        = wb_addr_q;
        fill_addr_d      = fill_addr_q;
        fill_pend_d      = fill_pend_q;
        wb_data_d        = wb_data_q;
        ram_valid_d      = 1'b0;
        ram_data_d       = ram_data_q;
        mem_address_d    = mem_address_q;
        mem_read_en_d    = mem_read_en_q;
        mem_write_en_d   = mem_write_en_q;
        mem_write_data_d = mem_write_data_q;
        case (state_q)
            IDLE: begin
                if (prop_write_en) begin
                    wb_addr_d        = prop_wb_address & ~OFF_MASK;
                    wb_data_d        = prop_write_data;
                    fill_addr_d      = prop_address;
                    fill_pend_d      = prop_read_en;
                    word_cnt_d       = '0;
                    xfer_cnt_d       = '0;
                    mem_write_en_d   = 1'b1;
                    mem_address_d    = word_addr(prop_wb_address, '0);
                    mem_write_data_d = prop_write_data[0];
                    state_d          = WB;
                end else if (prop_read_en) begin
                    fill_addr_d   = prop_address;
                    fill_pend_d   = 1'b0;
                    word_cnt_d    = start_in;
                    xfer_cnt_d    = '0;
                    mem_read_en_d = 1'b1;
                    mem_address_d = word_addr(prop_address, start_in);
                    state_d       = FILL;
                end
            end
            WB: begin
                if (mem_ack) begin
                    word_cnt_d = word_cnt_nxt;
                    xfer_cnt_d = xfer_cnt_nxt;
                    if (phase_last) begin
                        mem_write_en_d = 1'b0;
                        if (fill_pend_q) begin
                            word_cnt_d    = start_q;
                            xfer_cnt_d    = '0;
                            mem_read_en_d = 1'b1;
                            mem_address_d = word_addr(fill_addr_q, start_q);
                            state_d       = FILL;
                        end else begin
                            ram_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                    end else begin
                        mem_address_d    = word_addr(wb_addr_q, word_cnt_nxt);
                        mem_write_data_d = wb_data_q[word_cnt_nxt];
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    ram_data_d[word_cnt_q] = mem_read_data;
                    word_cnt_d = word_cnt_nxt;
                    xfer_cnt_d = xfer_cnt_nxt;
                    if (phase_last) begin
                        mem_read_en_d = 1'b0;
                        ram_valid_d   = 1'b1;
                        state_d       = DONE;
                    end else begin
                        mem_address_d = word_addr(fill_addr_q, word_cnt_nxt);
                    end
                end
            end
            DONE: begin
                hold_cnt_d = '0;
                state_d    = HOLD;
            end
            HOLD: begin
                // Gives the cache time to register ram_valid before it can re-request.
                if (hold_cnt_q == 4'(HOLD_CYCLES-1)) state_d = IDLE;
                else                                 hold_cnt_d = hold_cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            word_cnt_q       <= '0;
            xfer_cnt_q       <= '0;
            hold_cnt_q       <= '0;
            wb_addr_q        <= '0;
            fill_addr_q      <= '0;
            fill_pend_q      <= 1'b0;
            wb_data_q        <= '0;
            ram_valid_q      <= 1'b0;
            ram_data_q       <= '0;
            busy_q           <= 1'b0;
            mem_address_q    <= '0;
            mem_read_en_q    <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            word_cnt_q       <= word_cnt_d;
            xfer_cnt_q       <= xfer_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
            wb_addr_q        <= wb_addr_d;
            fill_addr_q      <= fill_addr_d;
            fill_pend_q      <= fill_pend_d;
            wb_data_q        <= wb_data_d;
            ram_valid_q      <= ram_valid_d;
            ram_data_q       <= ram_data_d;
            busy_q           <= busy_d;
            mem_address_q    <= mem_address_d;
            mem_read_en_q    <= mem_read_en_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign ram_valid      = ram_valid_q;
    assign ram_data       = ram_data_q;
    assign busy           = busy_q;
    assign mem_address    = mem_address_q;
    assign mem_read_en    = mem_read_en_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_write_data = mem_write_data_q;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: RAM returns its address as data, expected RAM transfers are
// queued when a request is issued and popped by a monitor on every acknowledged word.
module tb_cache_mem_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BS = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [AW-1:0]          prop_address, prop_wb_address;
    logic                   prop_read_en, prop_write_en;
    logic [BS-1:0][DW-1:0]  prop_write_data;
    logic                   ram_valid, busy;
    logic [BS-1:0][DW-1:0]  ram_data;
    logic [AW-1:0]          mem_address;
    logic                   mem_read_en, mem_write_en;
    logic [DW-1:0]          mem_write_data, mem_read_data;
    logic                   mem_ack;

    xfer_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    valid_cnt = 0;
    bit    stall = 0;
    bit    idle_ack = 0;

    cache_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .prop_address(prop_address), .prop_wb_address(prop_wb_address),
        .prop_read_en(prop_read_en), .prop_write_en(prop_write_en),
        .prop_write_data(prop_write_data),
        .ram_valid(ram_valid), .ram_data(ram_data), .busy(busy),
        .mem_address(mem_address), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_ack(mem_ack), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;
    assign mem_read_data = DW'(mem_address);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] blk(input logic [AW-1:0] b);
        logic [127:0] r;
        for (int i = 0; i < BS; i++) r[i*DW +: DW] = DW'(b + AW'(i));
        return r;
    endfunction

    task automatic push_fill(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        logic [1:0]    s;
        logic [1:0]    o;
        b = a & ~AW'(3);
`ifdef CACHE_MEM_CRITICAL_WORD_FIRST_EN
        s = a[1:0];
`else
        s = 2'd0;
`endif
        for (int i = 0; i < BS; i++) begin
            o = s + 2'(i);
            exp_q.push_back('{1'b0, b | AW'(o), DW'(b | AW'(o))});
        end
    endtask

    task automatic push_wb(input logic [AW-1:0] b, input logic [127:0] wd);
        for (int i = 0; i < BS; i++)
            exp_q.push_back('{1'b1, b | AW'(i), wd[i*DW +: DW]});
    endtask

    // Acknowledge driver: every word when not stalled, every 4th cycle when stalled.
    initial begin
        int sc;
        sc = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_read_en || mem_write_en) begin
                if (stall) begin
                    mem_ack = (sc == 3);
                    sc = (sc == 3) ? 0 : sc + 1;
                end else begin
                    mem_ack = 1'b1;
                end
            end else begin
                sc = 0;
                mem_ack = idle_ack;
            end
        end
    end

    // Monitor: scoreboard pops, exclusivity and stall stability.
    initial begin
        bit            prev_pend;
        logic [AW+DW+1:0] prev_sig;
        xfer_t         e;
        prev_pend = 0;
        prev_sig  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pend = 0;
            end else begin
                if (ram_valid) valid_cnt++;
                if (mem_read_en || mem_write_en)
                    chk("rw_exclusive", 128'(mem_read_en & mem_write_en), 128'(0));
                if (prev_pend)
                    chk("stall_stable", 128'({mem_address, mem_write_data, mem_read_en, mem_write_en}),
                        128'(prev_sig));
                if ((mem_read_en || mem_write_en) && mem_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_xfer", 128'(mem_address), 128'('1));
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_we", 128'(mem_write_en), 128'(e.we));
                        chk("xfer_addr", 128'(mem_address), 128'(e.addr));
                        if (e.we) chk("xfer_wdata", 128'(mem_write_data), 128'(e.data));
                    end
                end
                prev_pend = (mem_read_en || mem_write_en) && !mem_ack;
                prev_sig  = {mem_address, mem_write_data, mem_read_en, mem_write_en};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input bit we, input bit re, input logic [AW-1:0] wba,
                         input logic [AW-1:0] a, input logic [127:0] wd, input bit keep);
        @(negedge clk);
        prop_write_en   = we;
        prop_read_en    = re;
        prop_wb_address = wba;
        prop_address    = a;
        prop_write_data = wd;
        @(posedge clk);
        #1;
        if (!keep) begin
            prop_write_en = 1'b0;
            prop_read_en  = 1'b0;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ram_valid && n < 200);
        if (!ram_valid) chk("valid_timeout", 128'(ram_valid), 128'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) chk("idle_timeout", 128'(busy), 128'(0));
    endtask

    initial begin
        int            n;
        int            vc;
        logic [127:0]  wd;
        logic [127:0]  rd;

        reset = 1'b1;
        prop_address = '0; prop_wb_address = '0;
        prop_read_en = 1'b0; prop_write_en = 1'b0; prop_write_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ram_valid", 128'(ram_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_mem_en", 128'({mem_read_en, mem_write_en}), 128'(0));
        chk("rst_mem_addr", 128'({mem_address, mem_write_data}), 128'(0));
        chk("rst_ram_data", 128'(ram_data), 128'(0));
        reset = 1'b0;

        // Reset mid-fill after two acknowledged words.
        push_fill(10'h104);
        issue(0, 1, '0, 10'h104, '0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("partial_fill", 128'(ram_data), 128'({32'h105, 32'h104}));
        chk("partial_pending", 128'(exp_q.size()), 128'(2));
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_outputs", 128'({ram_valid, busy, mem_read_en, mem_write_en, mem_address, mem_write_data}),
            128'(0));
        chk("midrst_ram_data", 128'(ram_data), 128'(0));
        reset = 1'b0;
        push_fill(10'h104);
        issue(0, 1, '0, 10'h104, '0, 0);
        wait_valid(n);
        chk("fill104_latency", 128'(n), 128'(5));
        chk("fill104_data", 128'(ram_data), blk(10'h104));
        @(negedge clk);
        chk("fill104_pulse", 128'(ram_valid), 128'(0));

        // Fill from the middle of a block.
        wait_idle();
        push_fill(10'h106);
        issue(0, 1, '0, 10'h106, '0, 0);
        wait_valid(n);
        chk("fill106_latency", 128'(n), 128'(5));
        chk("fill106_data", 128'(ram_data), blk(10'h104));
        chk("fill106_drained", 128'(exp_q.size()), 128'(0));

        // Writeback followed by fill.
        wait_idle();
        wd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        vc = valid_cnt;
        push_wb(10'h2F0, wd);
        push_fill(10'h010);
        issue(1, 1, 10'h2F0, 10'h010, wd, 0);
        wait_valid(n);
        chk("wbfill_latency", 128'(n), 128'(9));
        chk("wbfill_data", 128'(ram_data), blk(10'h010));
        @(negedge clk);
        chk("wbfill_pulses", 128'(valid_cnt - vc), 128'(1));

        // Writeback only with three stall cycles per word.
        wait_idle();
        stall = 1;
        wd = {32'hDEAD0003, 32'hBEEF0002, 32'hCAFE0001, 32'h12340000};
        push_wb(10'h3FC, wd);
        issue(1, 0, 10'h3FC, 10'h055, wd, 0);
        wait_valid(n);
        chk("wbstall_latency", 128'(n), 128'(17));
        chk("wbstall_ram_data", 128'(ram_data), blk(10'h010));
        chk("wbstall_drained", 128'(exp_q.size()), 128'(0));
        stall = 0;

        // Request held through DONE/HOLD: second fill only after the hold window.
        wait_idle();
        vc = valid_cnt;
        push_fill(10'h020);
        issue(0, 1, '0, 10'h020, '0, 1);
        wait_valid(n);
        chk("held_latency", 128'(n), 128'(5));
        push_fill(10'h020);
        @(negedge clk);
        chk("held_done", 128'({ram_valid, busy, mem_read_en}), 128'(3'b010));
        @(negedge clk);
        chk("held_hold", 128'({busy, mem_read_en}), 128'(2'b10));
        @(negedge clk);
        chk("held_idle", 128'({busy, mem_read_en}), 128'(2'b00));
        @(negedge clk);
        chk("held_refill", 128'({busy, mem_read_en, mem_address}), 128'({2'b11, 10'h020}));
        prop_read_en = 1'b0;
        wait_valid(n);
        chk("held_refill_latency", 128'(n), 128'(4));
        wait_idle();
        repeat (3) @(negedge clk);
        chk("held_no_third", 128'({busy, mem_read_en}), 128'(0));
        chk("held_pulses", 128'(valid_cnt - vc), 128'(2));

        // Acknowledge while idle must be ignored.
        rd = ram_data;
        vc = valid_cnt;
        idle_ack = 1;
        repeat (4) @(negedge clk);
        chk("idleack_mem_ack_seen", 128'(mem_ack), 128'(1));
        chk("idleack_state", 128'({busy, ram_valid, mem_read_en, mem_write_en}), 128'(0));
        chk("idleack_ram_data", 128'(ram_data), rd);
        idle_ack = 0;
        repeat (2) @(negedge clk);
        chk("idleack_pulses", 128'(valid_cnt - vc), 128'(0));
        chk("final_drained", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
